// File: rtl/imu_burst_reader.sv
// SPI IMU front end: wakes the sensor, checks its identity, then burst-reads
// 16-bit big-endian words on a timer or data-ready trigger and publishes the kept channels.

module imu_spi_master #(
  parameter int CLK_DIV = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       miso,
  output logic       mosi,
  output logic       sclk,
  output logic       busy,
  output logic       done,
  output logic [7:0] data_out
);
  logic [15:0] div_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_sh;

  assign mosi = tx_sh[7];

  // SPI mode 0, MSB first: MISO sampled on rising SCLK, MOSI advanced on falling SCLK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      sclk     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy    <= 1'b1;
          tx_sh   <= data_in;
          div_cnt <= '0;
          bit_cnt <= '0;
        end
      end else if (div_cnt == 16'(CLK_DIV - 1)) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
        if (!sclk) begin
          data_out <= {data_out[6:0], miso};
        end else begin
          tx_sh   <= {tx_sh[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end
endmodule

module imu_burst_reader #(
  parameter int                     CLK_DIV     = 5,
  parameter int                     NUM_CH      = 6,
  parameter int                     BURST_WORDS = 7,
  parameter logic [BURST_WORDS-1:0] SKIP_MASK   = 7'h08,
  parameter logic [7:0]             START_ADDR  = 8'h3B,
  parameter logic [7:0]             PWR_ADDR    = 8'h6B,
  parameter logic [7:0]             PWR_VAL     = 8'h00,
  parameter logic [7:0]             ID_ADDR     = 8'h75,
  parameter logic [7:0]             ID_VAL      = 8'h70,
  parameter int                     MAX_RETRY   = 3,
  parameter int                     INIT_WAIT   = 100000,
  parameter int                     SAMPLE_DIV  = 100000,
  parameter int                     CS_GAP      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 drdy_mode,
  input  logic                 drdy,
  input  logic                 spi_miso,
  output logic                 spi_mosi,
  output logic                 spi_sclk,
  output logic                 spi_cs_n,
  output logic [NUM_CH*16-1:0] data,
  output logic                 valid,
  output logic [15:0]          sample_cnt,
  output logic                 ready,
  output logic                 overrun,
  output logic                 fault
);
  localparam logic [4:0]  LAST_BURST = 5'(2 * BURST_WORDS);
  localparam logic [15:0] SKIP16     = 16'(SKIP_MASK);
  localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRY);
  localparam int          SW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_WAIT, S_WAKE, S_IDCHK, S_IDLE, S_BURST, S_COMMIT, S_GAP, S_FAULT
  } state_t;

  state_t        state, state_next;
  logic          spi_start, spi_busy, spi_done;
  logic [7:0]    spi_tx, spi_rx;
  logic          xfer, gap_to_id, mode_q, mode_chg, tick, trig, pend;
  logic          capture_lo, keep;
  logic [4:0]    byte_idx, byte_last, wrd;
  logic [31:0]   cnt, timer;
  logic [3:0]    retries;
  logic [2:0]    drdy_sync;
  logic [7:0]    hi_byte;
  logic [SW-1:0] slot;
  logic [15:0]   shadow [NUM_CH];

  imu_spi_master #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk(clk), .rst_n(rst_n), .start(spi_start), .data_in(spi_tx), .miso(spi_miso),
    .mosi(spi_mosi), .sclk(spi_sclk), .busy(spi_busy), .done(spi_done), .data_out(spi_rx)
  );

  assign mode_chg   = (drdy_mode != mode_q);
  assign tick       = ready && (timer == 32'(SAMPLE_DIV - 1));
  assign trig       = ready && enable && (mode_q ? (drdy_sync[1] && !drdy_sync[2]) : tick);
  assign wrd        = byte_idx - 5'd1;
  assign capture_lo = (state == S_BURST) && xfer && spi_done && (byte_idx != 5'd0) && wrd[0];
  assign keep       = !SKIP16[wrd[4:1]];

  always_comb begin
    state_next = state;
    spi_start  = 1'b0;
    spi_tx     = 8'h00;
    byte_last  = LAST_BURST;
    case (state)
      S_WAIT:   if (cnt == 32'(INIT_WAIT - 1)) state_next = S_WAKE;
      S_WAKE, S_IDCHK, S_BURST: begin
        if (state != S_BURST) byte_last = 5'd1;
        spi_start = !xfer && !spi_busy;
        if (byte_idx == 5'd0)
          spi_tx = (state == S_WAKE)  ? PWR_ADDR :
                   (state == S_IDCHK) ? (ID_ADDR | 8'h80) : (START_ADDR | 8'h80);
        else if (state == S_WAKE)
          spi_tx = PWR_VAL;
        if (xfer && spi_done && byte_idx == byte_last) begin
          if (state == S_WAKE)          state_next = S_GAP;
          else if (state == S_BURST)    state_next = S_COMMIT;
          else if (spi_rx == ID_VAL)    state_next = S_GAP;
          else if (retries == RETRY_MAX) state_next = S_FAULT;
          else                          state_next = S_WAIT;
        end
      end
      S_COMMIT: state_next = S_GAP;
      S_GAP:    if (cnt == 32'(CS_GAP - 1)) state_next = gap_to_id ? S_IDCHK : S_IDLE;
      S_IDLE:   if (!mode_chg && enable && (pend || trig)) state_next = S_BURST;
      S_FAULT:  state_next = S_FAULT;
      default:  state_next = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_WAIT;
      cnt        <= '0;
      timer      <= '0;
      xfer       <= 1'b0;
      byte_idx   <= '0;
      retries    <= '0;
      gap_to_id  <= 1'b0;
      drdy_sync  <= '0;
      mode_q     <= 1'b0;
      pend       <= 1'b0;
      slot       <= '0;
      spi_cs_n   <= 1'b1;
      data       <= '0;
      valid      <= 1'b0;
      sample_cnt <= '0;
      ready      <= 1'b0;
      overrun    <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= (state_next != state) ? '0 : cnt + 32'd1;
      spi_cs_n  <= !(state_next inside {S_WAKE, S_IDCHK, S_BURST});
      valid     <= 1'b0;
      drdy_sync <= {drdy_sync[1:0], drdy};
      if (ready) timer <= tick ? '0 : timer + 32'd1;
      if (spi_start)     xfer <= 1'b1;
      else if (spi_done) xfer <= 1'b0;
      if (state_next != state)      byte_idx <= '0;
      else if (xfer && spi_done)    byte_idx <= byte_idx + 5'd1;
      if (state_next == S_GAP && state != S_GAP) gap_to_id <= (state == S_WAKE);
      if (state == S_IDCHK && state_next == S_GAP)  ready   <= 1'b1;
      if (state == S_IDCHK && state_next == S_WAIT) retries <= retries + 4'd1;
      if (state_next == S_FAULT) begin
        fault <= 1'b1;
        ready <= 1'b0;
      end
      // At most one trigger is held while a burst runs; a second one is an overrun.
      if (state == S_IDLE) begin
        if (mode_chg) begin
          mode_q <= drdy_mode;
          pend   <= 1'b0;
        end else if (state_next == S_BURST) begin
          pend <= pend && trig;
        end
      end else if ((state inside {S_BURST, S_COMMIT, S_GAP}) && trig) begin
        if (pend) overrun <= 1'b1;
        else      pend    <= 1'b1;
      end
      if (state != S_BURST)       slot <= '0;
      else if (capture_lo && keep) slot <= slot + 1'b1;
      if (state == S_COMMIT) begin
        valid      <= 1'b1;
        sample_cnt <= sample_cnt + 16'd1;
        for (int i = 0; i < NUM_CH; i++) data[i*16 +: 16] <= shadow[i];
      end
    end
  end

  // Burst words assemble in the shadow bank; data only sees complete bursts.
  always_ff @(posedge clk) begin
    if ((state == S_BURST) && xfer && spi_done && (byte_idx != 5'd0)) begin
      if (!wrd[0])   hi_byte      <= spi_rx;
      else if (keep) shadow[slot] <= {hi_byte, spi_rx};
    end
  end

  always_ff @(posedge clk)
    assert ($countones(~SKIP_MASK) == NUM_CH) else $error("SKIP_MASK keeps the wrong number of words");
endmodule
